sensor_ctrl: RTL and testbench
==============================

SENSOR_CTRL -- requirements
Module: sensor_ctrl

Interface
REQ-001 Parameter BURST_WORDS, default 8, words delivered per sensor_ready pulse.
REQ-002 Parameter DEPTH, default 64, buffer words; must be a multiple of BURST_WORDS.
REQ-003 cpu_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 cpu_rst  input  1  reset, asynchronous, active-low.
REQ-005 sctrl_en  input  1  CPU-side capture enable (level).
REQ-006 sctrl_clear  input  1  CPU-side clear (one-cycle pulse).
REQ-007 sctrl_addr  input  log2(DEPTH)  buffer read address.
REQ-008 sctrl_out  output  32  buffer read data, registered.
REQ-009 sctrl_int  output  1  buffer-full interrupt, level.
REQ-010 sensor_en  output  1  request to external sensor, registered.
REQ-011 sensor_ready  input  1  one-cycle strobe: sensor_out_0..7 valid.
REQ-012 sensor_out_0 .. sensor_out_7  input  32 each  sensor burst words.

Function
REQ-013 FSM states IDLE, CAPTURE, FULL.
REQ-014 IDLE: sctrl_en=1 and sctrl_clear=0 -> CAPTURE next edge.
REQ-015 CAPTURE: sensor_en=1 in every cycle where sctrl_en=1; otherwise 0 (pause); burst counter held during pause.
REQ-016 CAPTURE, sensor_ready=1, sctrl_en=1: write sensor_out_k to buffer[burst_cnt*BURST_WORDS+k], k=0..7, same edge; burst_cnt += 1.
REQ-017 sensor_ready in IDLE, FULL, or while paused: ignored, buffer unchanged.
REQ-018 Burst that fills last slot (burst_cnt = DEPTH/BURST_WORDS-1): -> FULL; sctrl_int=1 and sensor_en=0 from next cycle; counter wraps to 0.
REQ-019 FULL: held until sctrl_clear; no further writes.
REQ-020 sctrl_clear=1 in any state: -> IDLE, burst_cnt=0, sctrl_int=0, sensor_en=0 next edge; highest priority, overrides a simultaneous sensor_ready (burst discarded) and sctrl_en.
REQ-021 Clear does not erase buffer contents.
REQ-022 sctrl_out = buffer[sctrl_addr] sampled at edge N, visible after edge N (1-cycle latency); reads allowed in any state; a read of a slot written on the same edge returns the old value.
REQ-023 sensor_en deasserts the cycle after sctrl_en drops (registered).

Reset
REQ-024 cpu_rst low: state=IDLE, burst_cnt=0, sensor_en=0, sctrl_int=0, sctrl_out=0, immediately and asynchronously.
REQ-025 Buffer contents not reset (don't-care after reset); reset mid-CAPTURE abandons partial capture.
REQ-026 First capture after reset release requires sctrl_en sampled high at a rising edge.

Structure
REQ-027 Package sensor_pkg holds the state enum, BURST_WORDS and DEPTH defaults, and the 32-bit word typedef.
REQ-028 Sub-module sctrl_buf: DEPTH x 32 register array, one BURST_WORDS-wide aligned write port, one registered read port; the FSM and counter live in sensor_ctrl.

Verification
REQ-029 Reset, sctrl_en=1, 8 ready strobes with words 0x1000+i (i=0..63) -> sctrl_int=1 one cycle after 8th strobe, sensor_en=0, reads addr 0..63 return 0x1000..0x103F.
REQ-030 sctrl_en dropped after 3 bursts, 2 strobes while paused, re-enabled, 5 bursts -> paused strobes dropped; addr 24 holds first word of 4th real burst.
REQ-031 In FULL, extra sensor_ready with 0xDEADBEEF -> buffer unchanged, sctrl_int stays 1; sctrl_clear -> sctrl_int=0, IDLE, next capture writes addr 0..7.
REQ-032 sctrl_clear and sensor_ready same cycle in CAPTURE with burst_cnt=2 -> burst discarded, burst_cnt=0, addr 16..23 keep prior values.
REQ-033 cpu_rst asserted mid-cycle during CAPTURE -> sensor_en and sctrl_int 0 before next edge; after release and re-enable capture restarts at addr 0.
REQ-034 Read addr 5 on the edge a burst writes addr 0..7 -> sctrl_out shows old value, next read shows new value.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and defaults for the sensor capture controller.
// Holds FSM encoding, buffer geometry defaults and the data word type.
package sensor_pkg;

  localparam int DEF_BURST_WORDS = 8;
  localparam int DEF_DEPTH       = 64;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/sctrl_buf.sv
// Capture buffer: DEPTH x 32 array with one aligned burst write port
// and one registered read port (read returns pre-write data).
module sctrl_buf
  import sensor_pkg::*;
#(
  parameter int BW    = DEF_BURST_WORDS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int BIW   = (DEPTH / BW > 1) ? $clog2(DEPTH / BW) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [BIW-1:0] wburst,
  input  word_t          wdata [BW],
  input  logic [AW-1:0]  raddr,
  output word_t          rdata
);

  typedef logic [AW-1:0] addr_t;

  word_t mem [DEPTH];

  // Burst write: BW consecutive words into the slot picked by wburst.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BW; k++) begin
        mem[addr_t'(int'(wburst) * BW + k)] <= wdata[k];
      end
    end
  end

  // Registered read port; only this flop is reset, the array is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/sensor_ctrl.sv
// Sensor capture controller: sequences burst captures from an external
// sensor into a buffer and raises a level interrupt when it is full.
module sensor_ctrl
  import sensor_pkg::*;
#(
  parameter int BURST_WORDS = DEF_BURST_WORDS,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  input  logic                     sctrl_en,
  input  logic                     sctrl_clear,
  input  logic [$clog2(DEPTH)-1:0] sctrl_addr,
  output logic [31:0]              sctrl_out,
  output logic                     sctrl_int,
  output logic                     sensor_en,
  input  logic                     sensor_ready,
  input  logic [31:0]              sensor_out_0,
  input  logic [31:0]              sensor_out_1,
  input  logic [31:0]              sensor_out_2,
  input  logic [31:0]              sensor_out_3,
  input  logic [31:0]              sensor_out_4,
  input  logic [31:0]              sensor_out_5,
  input  logic [31:0]              sensor_out_6,
  input  logic [31:0]              sensor_out_7
);

  localparam int NB  = DEPTH / BURST_WORDS;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BIW-1:0] LAST = BIW'(NB - 1);

  state_t         state;
  state_t         state_nx;
  logic [BIW-1:0] burst_cnt;
  logic           wr;
  logic           last;
  logic           start;
  logic           en_nx;
  word_t          words [BURST_WORDS];

  // Gather the sensor burst lanes into one write bundle.
  always_comb begin
    words[0] = sensor_out_0;
    words[1] = sensor_out_1;
    words[2] = sensor_out_2;
    words[3] = sensor_out_3;
    words[4] = sensor_out_4;
    words[5] = sensor_out_5;
    words[6] = sensor_out_6;
    words[7] = sensor_out_7;
  end

  // A strobe is taken only while actively capturing and not cleared.
  assign wr    = (state == CAPTURE) && sctrl_en
               && sensor_ready && !sctrl_clear;
  assign last  = (burst_cnt == LAST);
  assign start = (state == IDLE) && sctrl_en && !sctrl_clear;

  // State register.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state: clear wins over everything else.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      sctrl_clear: state_nx = IDLE;
      start:       state_nx = CAPTURE;
      wr && last:  state_nx = FULL;
      default:     state_nx = state;
    endcase
  end

  // Outputs: interrupt decodes FULL, sensor request follows enable.
  always_comb begin
    sctrl_int = (state == FULL);
    en_nx     = (state_nx == CAPTURE) && sctrl_en;
  end

  // Registered sensor request.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) sensor_en <= 1'b0;
    else          sensor_en <= en_nx;
  end

  // Burst counter: held while paused, wraps after the last burst.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst)         burst_cnt <= '0;
    else if (sctrl_clear) burst_cnt <= '0;
    else if (wr)          burst_cnt <= last ? '0 : burst_cnt + 1'b1;
  end

  sctrl_buf #(
    .BW    (BURST_WORDS),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk    (cpu_clk),
    .rst_n  (cpu_rst),
    .we     (wr),
    .wburst (burst_cnt),
    .wdata  (words),
    .raddr  (sctrl_addr),
    .rdata  (sctrl_out)
  );

endmodule

// File: tb/tb_sensor_ctrl.sv
// Self-checking bench for sensor_ctrl: vector table for a full capture,
// directed sequences for pause, clear, reset and read-during-write.
module tb_sensor_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [5:0]  addr;
  logic [31:0] dout;
  logic        irq;
  logic        sen;
  logic        rdy;
  logic [31:0] so [8];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        clr;
    logic        rdy;
    logic [31:0] base;
    logic        exp_sen;
    logic        exp_int;
  } vec_t;

  vec_t vecs [10];

  sensor_ctrl dut (
    .cpu_clk      (clk),
    .cpu_rst      (rst_n),
    .sctrl_en     (en),
    .sctrl_clear  (clr),
    .sctrl_addr   (addr),
    .sctrl_out    (dout),
    .sctrl_int    (irq),
    .sensor_en    (sen),
    .sensor_ready (rdy),
    .sensor_out_0 (so[0]),
    .sensor_out_1 (so[1]),
    .sensor_out_2 (so[2]),
    .sensor_out_3 (so[3]),
    .sensor_out_4 (so[4]),
    .sensor_out_5 (so[5]),
    .sensor_out_6 (so[6]),
    .sensor_out_7 (so[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_words(input logic [31:0] base, input bit same);
    for (int k = 0; k < 8; k++) so[k] = same ? base : base + k;
  endtask

  task automatic cyc(input logic e, input logic c, input logic r,
                     input logic [31:0] base);
    en  = e;
    clr = c;
    rdy = r;
    set_words(base, 1'b0);
    @(posedge clk);
    #1;
    rdy = 1'b0;
    clr = 1'b0;
  endtask

  task automatic burst(input logic [31:0] base);
    cyc(1'b1, 1'b0, 1'b1, base);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp,
                    input string name);
    addr = a;
    rdy  = 1'b0;
    clr  = 1'b0;
    @(posedge clk);
    #1;
    chk(name, dout, exp);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      vecs[i].en      = 1'b1;
      vecs[i].clr     = 1'b0;
      vecs[i].rdy     = (i >= 1 && i <= 8);
      vecs[i].base    = 32'h1000 + 32'((i - 1) * 8);
      vecs[i].exp_sen = (i < 8);
      vecs[i].exp_int = (i >= 8);
    end

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    rdy   = 1'b0;
    addr  = '0;
    set_words(32'h0, 1'b0);
    #1;
    chk("rst_sen", {31'd0, sen}, 32'd0);
    chk("rst_int", {31'd0, irq}, 32'd0);
    chk("rst_out", dout, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full capture of 64 words.
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].en, vecs[i].clr, vecs[i].rdy, vecs[i].base);
      chk($sformatf("full_sen%0d", i), {31'd0, sen},
          {31'd0, vecs[i].exp_sen});
      chk($sformatf("full_int%0d", i), {31'd0, irq},
          {31'd0, vecs[i].exp_int});
    end
    for (int i = 0; i < 64; i++)
      rd(6'(i), 32'h1000 + 32'(i), $sformatf("full_rd%0d", i));

    // Strobe in FULL is ignored.
    en  = 1'b1;
    rdy = 1'b1;
    set_words(32'hDEADBEEF, 1'b1);
    @(posedge clk);
    #1;
    rdy = 1'b0;
    chk("full_hold_int", {31'd0, irq}, 32'd1);
    chk("full_hold_sen", {31'd0, sen}, 32'd0);
    rd(6'd0, 32'h1000, "full_nowr0");
    rd(6'd63, 32'h103F, "full_nowr63");

    // Clear, then capture restarts at address 0.
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("clr_int", {31'd0, irq}, 32'd0);
    chk("clr_sen", {31'd0, sen}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("restart_sen", {31'd0, sen}, 32'd1);
    burst(32'h2000);
    for (int k = 0; k < 8; k++)
      rd(6'(k), 32'h2000 + 32'(k), $sformatf("restart_rd%0d", k));
    rd(6'd8, 32'h1008, "restart_keep8");

    // Clear collides with a strobe at burst_cnt=2.
    burst(32'h3000);
    cyc(1'b1, 1'b1, 1'b1, 32'h4000);
    chk("coll_sen", {31'd0, sen}, 32'd0);
    chk("coll_int", {31'd0, irq}, 32'd0);
    for (int k = 16; k < 24; k++)
      rd(6'(k), 32'h1000 + 32'(k), $sformatf("coll_keep%0d", k));
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    burst(32'h5000);
    rd(6'd0, 32'h5000, "coll_cnt0_a0");
    rd(6'd7, 32'h5007, "coll_cnt0_a7");
    rd(6'd8, 32'h3000, "coll_keep8");

    // Pause drops strobes and holds the burst counter.
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int j = 0; j < 3; j++) burst(32'h6000 + 32'(j * 8));
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pause_sen", {31'd0, sen}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h7000);
    cyc(1'b0, 1'b0, 1'b1, 32'h7100);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("resume_sen", {31'd0, sen}, 32'd1);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("resume_int%0d", j), {31'd0, irq}, 32'd0);
      burst(32'h6018 + 32'(j * 8));
    end
    chk("resume_full_int", {31'd0, irq}, 32'd1);
    chk("resume_full_sen", {31'd0, sen}, 32'd0);
    rd(6'd24, 32'h6018, "pause_a24");
    rd(6'd23, 32'h6017, "pause_a23");
    rd(6'd63, 32'h603F, "pause_a63");

    // Read of a slot written on the same edge returns old data.
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    addr = 6'd5;
    burst(32'h8000);
    chk("rdw_old", dout, 32'h6005);
    rd(6'd5, 32'h8005, "rdw_new");

    // Asynchronous reset mid-capture.
    burst(32'h9000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_sen", {31'd0, sen}, 32'd0);
    chk("arst_int", {31'd0, irq}, 32'd0);
    chk("arst_out", dout, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 32'hB000);
    chk("arst_idle_sen", {31'd0, sen}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("arst_go_sen", {31'd0, sen}, 32'd1);
    burst(32'hA000);
    rd(6'd0, 32'hA000, "arst_a0");
    rd(6'd7, 32'hA007, "arst_a7");
    rd(6'd8, 32'h9000, "arst_keep8");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
